ddr_rd_stream: RTL and testbench

- Read-side consumer of the DDR address/FIFO top.
- Pulls 16-bit words from the DDR read FIFO in the clk_150_90 domain. Uses the FIFO's non-empty flag (read_en) and its read strobe (read_req).
- Packs the words into fixed-length frames with a valid/ready handshake for the downstream DSP datapath.
- Tolerates the FIFO's one-cycle read latency and downstream back-pressure without losing or duplicating words.

---
 rtl/ddr_rd_stream.sv | 160 ++++++++++++++++
 tb/tb_ddr_rd_stream.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_stream.sv
// ddr_rd_stream: read-side consumer of the DDR read FIFO (clk_150_90 domain).
// Issues FIFO reads under a credit rule that accounts for the FIFO's one-cycle
// read latency. Returned words land in a small circular skid buffer, and the
// buffer head drives a valid/ready stream framed with sof/eof. Frames are
// frame_len words long. They run singly or back-to-back until a stop arrives.
module ddr_rd_stream #(
    parameter int DW        = 16,
    parameter int LW        = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cont,
    input  logic          stop,
    input  logic [LW-1:0] frame_len,
    input  logic          read_en,
    output logic          read_req,
    input  logic [DW-1:0] read_data,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_sof,
    output logic          m_eof,
    output logic [LW-1:0] frame_cnt,
    output logic          busy,
    output logic          len_err
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                       state;
    logic [LW-1:0]                len_q;
    logic [LW-1:0]                req_cnt;
    logic [LW-1:0]                out_cnt;
    logic                         cont_q;
    logic                         stop_pend;
    logic                         inflight;

    logic [BUF_DEPTH-1:0][DW-1:0] buf_mem;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [CW-1:0]                buf_cnt;

    logic [CW:0]                  slots_used;
    logic                         pop;
    logic                         eof_xfer;
    logic                         last_req;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Stream side is driven straight from the buffer head.
    assign m_valid  = (buf_cnt != '0);
    assign m_data   = buf_mem[rd_ptr];
    assign m_sof    = m_valid & (out_cnt == '0);
    assign m_eof    = m_valid & (out_cnt == len_q - LW'(1));
    assign pop      = m_valid & m_ready;
    assign eof_xfer = pop & m_eof;
    assign busy     = (state != IDLE);

    // Slots committed once this cycle's pop retires. A word already in flight
    // holds a slot. A pop in the same cycle frees one, which lets a two-entry
    // buffer sustain one word per cycle.
    assign slots_used = {1'b0, buf_cnt} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

    assign read_req = (state == RUN) & read_en & (req_cnt < len_q)
                    & (slots_used < (CW+1)'(BUF_DEPTH));
    assign last_req = read_req & ((req_cnt + LW'(1)) == len_q);

    // Skid buffer: capture the word returned for last cycle's read, retire on transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= '0;
        end else begin
            if (inflight) begin
                buf_mem[wr_ptr] <= read_data;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (inflight && !pop)
                buf_cnt <= buf_cnt + CW'(1);
            else if (!inflight && pop)
                buf_cnt <= buf_cnt - CW'(1);
        end
    end

    // Frame control: run/drain sequencing, per-frame counters and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= '0;
            cont_q    <= 1'b0;
            req_cnt   <= '0;
            out_cnt   <= '0;
            frame_cnt <= '0;
            len_err   <= 1'b0;
            stop_pend <= 1'b0;
            inflight  <= 1'b0;
        end else begin
            inflight <= read_req;
            if (read_req)
                req_cnt <= req_cnt + LW'(1);
            if (pop)
                out_cnt <= eof_xfer ? '0 : out_cnt + LW'(1);
            if (eof_xfer)
                frame_cnt <= frame_cnt + LW'(1);

            case (state)
                IDLE: begin
                    // stop is ignored here; start takes priority when both arrive
                    if (start) begin
                        if (frame_len != '0) begin
                            len_q     <= frame_len;
                            cont_q    <= cont;
                            req_cnt   <= '0;
                            out_cnt   <= '0;
                            frame_cnt <= '0;
                            len_err   <= 1'b0;
                            stop_pend <= 1'b0;
                            state     <= RUN;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (last_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    // a stop landing on the eof cycle still ends the run
                    if (eof_xfer) begin
                        req_cnt <= '0;
                        if (cont_q && !stop_pend && !stop) begin
                            state <= RUN;
                        end else begin
                            state     <= IDLE;
                            stop_pend <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_stream.sv
// Bench for ddr_rd_stream: FIFO model with one-cycle read latency, a
// ready-pattern driver, a transfer monitor, and directed frame scenarios.
module tb_ddr_rd_stream;

    localparam int DW = 16;
    localparam int LW = 16;
    localparam int BD = 2;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic          cont      = 1'b0;
    logic          stop      = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          read_en;
    logic          read_req;
    logic [DW-1:0] read_data = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready   = 1'b1;
    logic          m_sof;
    logic          m_eof;
    logic [LW-1:0] frame_cnt;
    logic          busy;
    logic          len_err;

    ddr_rd_stream #(.DW(DW), .LW(LW), .BUF_DEPTH(BD)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cont      (cont),
        .stop      (stop),
        .frame_len (frame_len),
        .read_en   (read_en),
        .read_req  (read_req),
        .read_data (read_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .frame_cnt (frame_cnt),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    // FIFO model: main process appends at fifo_wp, reads pop at fifo_rp.
    logic [DW-1:0] fifo_mem [0:255];
    int            fifo_wp = 0;
    int            fifo_rp = 0;
    logic          en_gate = 1'b1;

    assign read_en = (fifo_wp != fifo_rp) && en_gate;

    // One-cycle read latency, like the DDR read FIFO.
    always @(posedge clk) begin
        if (read_req) begin
            read_data <= fifo_mem[fifo_rp % 256];
            fifo_rp   <= fifo_rp + 1;
        end
    end

    // Downstream ready: mode 0 always ready, mode 1 repeats 1,0,0,1.
    int rdy_mode = 0;
    int rdy_ph   = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            m_ready = 1'b1;
        end else begin
            m_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
            rdy_ph  = rdy_ph + 1;
        end
    end

    // Monitor: log transfers and read requests, watch stall stability and occupancy.
    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          eof;
        int            c;
    } xfer_t;

    int            cyc = 0;
    xfer_t         cap[$];
    int            rr_cyc[$];
    int            stall_viol = 0;
    int            ovf_viol   = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d     = '0;
    logic          prev_sof   = 1'b0;
    logic          prev_eof   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall && (!m_valid || m_data != prev_d || m_sof != prev_sof || m_eof != prev_eof))
                stall_viol <= stall_viol + 1;
            if (dut.buf_cnt > BD)
                ovf_viol <= ovf_viol + 1;
            if (read_req)
                rr_cyc.push_back(cyc);
            if (m_valid && m_ready)
                cap.push_back(xfer_t'{m_data, m_sof, m_eof, cyc});
            prev_stall <= m_valid && !m_ready;
            prev_d     <= m_data;
            prev_sof   <= m_sof;
            prev_eof   <= m_eof;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic xfer_t cap_at(input int i);
        xfer_t z;
        z.d = '0; z.sof = 1'b0; z.eof = 1'b0; z.c = -1000;
        if (i >= 0 && i < cap.size()) z = cap[i];
        return z;
    endfunction

    function automatic int rr_at(input int i);
        if (i >= 0 && i < rr_cyc.size()) return rr_cyc[i];
        return -1000;
    endfunction

    task automatic fifo_push(input logic [DW-1:0] d);
        fifo_mem[fifo_wp % 256] = d;
        fifo_wp++;
    endtask

    task automatic pulse_start(input int len, input logic c);
        @(posedge clk); #1;
        frame_len = LW'(len);
        cont      = c;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Returns on the first falling edge where busy is low, bounded.
    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            if (!busy) break;
            k++;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    typedef struct {
        int            len;
        int            rdy;
        logic [DW-1:0] base;
        int            exp_n;
        logic [DW-1:0] exp_last;
    } vec_t;

    vec_t vt[5];

    initial begin
        int b, r, sv, ov, n;
        xfer_t x;

        vt[0] = '{len: 8, rdy: 1, base: 16'h0200, exp_n: 8, exp_last: 16'h0207};
        vt[1] = '{len: 1, rdy: 0, base: 16'h0300, exp_n: 1, exp_last: 16'h0300};
        vt[2] = '{len: 3, rdy: 1, base: 16'h0400, exp_n: 3, exp_last: 16'h0402};
        vt[3] = '{len: 2, rdy: 0, base: 16'h0500, exp_n: 2, exp_last: 16'h0501};
        vt[4] = '{len: 5, rdy: 1, base: 16'h0600, exp_n: 5, exp_last: 16'h0604};

        // Reset state
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", m_valid, 0);
        check("rst_req", read_req, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_lenerr", len_err, 0);
        #11 reset = 1'b1;

        // Basic frame: 4 words, latency 2, one word per cycle
        rdy_mode = 0;
        b = cap.size(); r = rr_cyc.size();
        for (int k = 1; k <= 4; k++) fifo_push(DW'(k));
        pulse_start(4, 1'b0);
        wait_idle("t1", 100);
        check("t1_nreq", rr_cyc.size() - r, 4);
        check("t1_req_span", rr_at(r + 3) - rr_at(r), 3);
        check("t1_nwords", cap.size() - b, 4);
        check("t1_latency", cap_at(b).c - rr_at(r), 2);
        check("t1_xfer_span", cap_at(b + 3).c - cap_at(b).c, 3);
        for (int k = 0; k < 4; k++) begin
            x = cap_at(b + k);
            check($sformatf("t1_d%0d", k), x.d, k + 1);
            check($sformatf("t1_sof%0d", k), x.sof, (k == 0) ? 1 : 0);
            check($sformatf("t1_eof%0d", k), x.eof, (k == 3) ? 1 : 0);
        end
        check("t1_fcnt", frame_cnt, 1);
        check("t1_busy_drop", cyc - cap_at(b + 3).c, 1);

        // Table of single frames with and without back-pressure
        for (int i = 0; i < 5; i++) begin
            rdy_mode = vt[i].rdy;
            b = cap.size(); sv = stall_viol; ov = ovf_viol;
            for (int k = 0; k < vt[i].len; k++) fifo_push(vt[i].base + DW'(k));
            pulse_start(vt[i].len, 1'b0);
            wait_idle($sformatf("v%0d", i), 300);
            check($sformatf("v%0d_nwords", i), cap.size() - b, vt[i].exp_n);
            for (int k = 0; k < vt[i].len; k++) begin
                x = cap_at(b + k);
                check($sformatf("v%0d_d%0d", i, k), x.d, vt[i].base + DW'(k));
                check($sformatf("v%0d_sof%0d", i, k), x.sof, (k == 0) ? 1 : 0);
                check($sformatf("v%0d_eof%0d", i, k), x.eof, (k == vt[i].len - 1) ? 1 : 0);
            end
            check($sformatf("v%0d_last", i), cap_at(b + vt[i].exp_n - 1).d, vt[i].exp_last);
            check($sformatf("v%0d_fcnt", i), frame_cnt, 1);
            check($sformatf("v%0d_stall", i), stall_viol - sv, 0);
            check($sformatf("v%0d_ovf", i), ovf_viol - ov, 0);
        end
        rdy_mode = 0;

        // Continuous frames of 3, stop during the second frame
        b = cap.size(); r = rr_cyc.size();
        for (int k = 0; k < 9; k++) fifo_push(16'h0100 + DW'(k));
        pulse_start(3, 1'b1);
        n = 0;
        while (frame_cnt != 1 && n < 100) begin @(negedge clk); n++; end
        check("t3_first_frame", frame_cnt, 1);
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        wait_idle("t3", 200);
        check("t3_nwords", cap.size() - b, 6);
        check("t3_nreq", rr_cyc.size() - r, 6);
        for (int k = 0; k < 6; k++) begin
            x = cap_at(b + k);
            check($sformatf("t3_d%0d", k), x.d, 16'h0100 + k);
            check($sformatf("t3_eof%0d", k), x.eof, (k == 2 || k == 5) ? 1 : 0);
        end
        check("t3_fcnt", frame_cnt, 2);
        check("t3_fifo_left", fifo_wp - fifo_rp, 3);

        // Drain the three words left behind
        b = cap.size();
        pulse_start(3, 1'b0);
        wait_idle("t3b", 100);
        check("t3b_nwords", cap.size() - b, 3);
        check("t3b_first", cap_at(b).d, 16'h0106);
        check("t3b_last", cap_at(b + 2).d, 16'h0108);

        // read_en low for 10 cycles after two requests
        b = cap.size(); r = rr_cyc.size();
        for (int k = 0; k < 5; k++) fifo_push(16'h0700 + DW'(k));
        pulse_start(5, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1; en_gate = 1'b0;
        repeat (10) @(posedge clk);
        #1; en_gate = 1'b1;
        wait_idle("t4", 200);
        check("t4_nwords", cap.size() - b, 5);
        check("t4_nreq", rr_cyc.size() - r, 5);
        for (int k = 0; k < 5; k++) begin
            x = cap_at(b + k);
            check($sformatf("t4_d%0d", k), x.d, 16'h0700 + k);
            check($sformatf("t4_sof%0d", k), x.sof, (k == 0) ? 1 : 0);
            check($sformatf("t4_eof%0d", k), x.eof, (k == 4) ? 1 : 0);
        end
        check("t4_gap", (cap_at(b + 2).c - cap_at(b + 1).c) > 8, 1);

        // Zero length is rejected, then a one-word frame clears the error
        r = rr_cyc.size();
        pulse_start(0, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_lenerr", len_err, 1);
        check("t5_busy", busy, 0);
        check("t5_noreq", rr_cyc.size() - r, 0);
        fifo_push(16'h0801);
        b = cap.size();
        pulse_start(1, 1'b0);
        check("t5_lenerr_clr", len_err, 0);
        check("t5_busy_run", busy, 1);
        wait_idle("t5", 100);
        check("t5_nwords", cap.size() - b, 1);
        x = cap_at(b);
        check("t5_d", x.d, 16'h0801);
        check("t5_sof", x.sof, 1);
        check("t5_eof", x.eof, 1);
        check("t5_fcnt", frame_cnt, 1);

        // Asynchronous reset mid-frame
        b = cap.size();
        for (int k = 0; k < 6; k++) fifo_push(16'h0900 + DW'(k));
        pulse_start(6, 1'b0);
        n = 0;
        while ((cap.size() - b) < 2 && n < 100) begin @(negedge clk); n++; end
        check("t6_two_words", cap.size() - b, 2);
        check("t6_busy_pre", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_valid", m_valid, 0);
        check("t6_data", m_data, 0);
        check("t6_sof", m_sof, 0);
        check("t6_eof", m_eof, 0);
        check("t6_req", read_req, 0);
        check("t6_busy", busy, 0);
        check("t6_fcnt", frame_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        r = rr_cyc.size();
        repeat (10) @(negedge clk);
        check("t6_noreq", rr_cyc.size() - r, 0);
        check("t6_idle", busy, 0);
        check("t6_valid_after", m_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
        $fatal(1);
    end

endmodule
